clefia_dp_sequencer: RTL and testbench

Control sequencer that drives the `data_processing` datapath through a full CLEFIA GFN run. It sits directly upstream of `data_processing` and generates, every clock, the mux selects (`sel_mux_1..5`) and the F0/F1 select (`selecao_f0_f1`). It also issues the address of the round key or constant word to a synchronous-read key RAM/ROM, so that `round_key` arrives aligned with the selects. It covers three runs: 128-bit encryption (GFN4,18), 128-bit key expansion (GFN4,12) and 192/256-bit key expansion (GFN8,10).

---
 rtl/clefia_pkg.sv | 31 +++
 rtl/clefia_dp_sequencer_if.sv | 17 +
 rtl/clefia_sel_decode.sv | 17 +
 rtl/clefia_dp_sequencer.sv | 65 ++++++
 tb/tb_clefia_dp_sequencer.sv | 139 +++++++++++++
 5 files changed

// File: rtl/clefia_pkg.sv
// clefia_pkg: shared mode, phase-count, select-encoding and state definitions for the CLEFIA sequencer
package clefia_pkg;
  typedef enum logic [1:0] {
    MODE_ENC128 = 2'd0,
    MODE_KEY128 = 2'd1,
    MODE_KEY256 = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;
  localparam logic [5:0] N_ENC128 = 6'd36;
  localparam logic [5:0] N_KEY128 = 6'd24;
  localparam logic [5:0] N_KEY256 = 6'd40;
  typedef enum logic [2:0] {IDLE, PREFETCH, RUN, DRAIN1, DRAIN2} state_e;
  typedef struct packed {
    logic [1:0] mux1;
    logic       mux2;
    logic [1:0] mux3;
    logic [2:0] mux4;
    logic       mux5;
    logic       f;
  } sel_t;
  localparam sel_t SEL_ZERO    = '0;
  localparam sel_t SEL_G4_P1   = '{2'd3, 1'b0, 2'd0, 3'd1, 1'b0, 1'b1};
  localparam sel_t SEL_G4_EVEN = '{2'd3, 1'b1, 2'd2, 3'd1, 1'b1, 1'b0};
  localparam sel_t SEL_G4_ODD  = '{2'd3, 1'b1, 2'd1, 3'd1, 1'b1, 1'b1};
  localparam sel_t SEL_G8_P1   = '{2'd3, 1'b0, 2'd0, 3'd1, 1'b0, 1'b1};
  localparam sel_t SEL_G8_P2   = '{2'd1, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0};
  localparam sel_t SEL_G8_P3   = '{2'd2, 1'b0, 2'd0, 3'd3, 1'b0, 1'b1};
  function automatic logic [5:0] n_phases(mode_e m);
    return m == MODE_KEY128 ? N_KEY128 : m == MODE_KEY256 ? N_KEY256 : N_ENC128;
  endfunction
endpackage

// File: rtl/clefia_dp_sequencer_if.sv
// clefia_dp_sequencer_if: run request and datapath control bundle of the CLEFIA sequencer
interface clefia_dp_sequencer_if;
  logic       start;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic [5:0] rk_addr;
  logic [1:0] rk_bank;
  logic [1:0] sel_mux_1;
  logic       sel_mux_2;
  logic [1:0] sel_mux_3;
  logic [2:0] sel_mux_4;
  logic       sel_mux_5;
  logic       selecao_f0_f1;
  modport master (output start, mode, input busy, done, rk_addr, rk_bank, sel_mux_1, sel_mux_2, sel_mux_3, sel_mux_4, sel_mux_5, selecao_f0_f1);
  modport slave (input start, mode, output busy, done, rk_addr, rk_bank, sel_mux_1, sel_mux_2, sel_mux_3, sel_mux_4, sel_mux_5, selecao_f0_f1);
endinterface

// File: rtl/clefia_sel_decode.sv
// clefia_sel_decode: combinational (mode, phase) to datapath select bundle for GFN4 and GFN8 runs
module clefia_sel_decode
  import clefia_pkg::*;
(
  input  mode_e      mode,
  input  logic [5:0] phase,
  output sel_t       sel
);
  sel_t g4, g8;
  // GFN8 steady state repeats every four phases starting at phase 4, so phase[1:0] is the position in the cycle
  always_comb begin
    g4 = phase == 6'd0 ? SEL_ZERO : phase == 6'd1 ? SEL_G4_P1 : phase[0] ? SEL_G4_ODD : SEL_G4_EVEN;
    g8 = phase == 6'd0 ? SEL_ZERO : phase == 6'd1 ? SEL_G8_P1 : phase == 6'd2 ? SEL_G8_P2 : phase == 6'd3 ? SEL_G8_P3 :
         sel_t'{2'd2, 1'b1, {1'b0, phase[1:0] != 2'd3}, 3'd4, 1'b0, phase[0]};
    sel = mode == MODE_KEY256 ? g8 : g4;
  end
endmodule

// File: rtl/clefia_dp_sequencer.sv
// clefia_dp_sequencer: sequences data_processing selects and key-store addresses through a full CLEFIA GFN run
module clefia_dp_sequencer
  import clefia_pkg::*;
(
  input logic clk,
  input logic rst,
  clefia_dp_sequencer_if.slave bus
);
  state_e     state;
  mode_e      bank;
  logic [5:0] cnt, n, addr_q;
  logic       busy_q, done_q;
  sel_t       sel_q, sel_d;
  clefia_sel_decode u_dec (.mode(bank), .phase(cnt), .sel(sel_d));
  assign n = n_phases(bank);
  // cnt is the phase presented next; the address runs one phase ahead so the key word lands with its selects
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bank   <= MODE_ENC128;
      cnt    <= '0;
      addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sel_q  <= SEL_ZERO;
    end else begin
      case (state)
        IDLE: if (bus.start && bus.mode != MODE_RSVD) begin
          state  <= PREFETCH;
          bank   <= mode_e'(bus.mode);
          cnt    <= '0;
          addr_q <= '0;
          busy_q <= 1'b1;
        end
        PREFETCH, RUN: if (cnt == n) state <= DRAIN1;
        else begin
          state  <= RUN;
          sel_q  <= sel_d;
          addr_q <= cnt + 6'd1 == n ? n - 6'd1 : cnt + 6'd1;
          cnt    <= cnt + 6'd1;
        end
        DRAIN1: begin
          state  <= DRAIN2;
          done_q <= 1'b1;
        end
        DRAIN2: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.rk_addr       = addr_q;
  assign bus.rk_bank       = bank;
  assign bus.sel_mux_1     = sel_q.mux1;
  assign bus.sel_mux_2     = sel_q.mux2;
  assign bus.sel_mux_3     = sel_q.mux3;
  assign bus.sel_mux_4     = sel_q.mux4;
  assign bus.sel_mux_5     = sel_q.mux5;
  assign bus.selecao_f0_f1 = sel_q.f;
endmodule

// File: tb/tb_clefia_dp_sequencer.sv
// tb_clefia_dp_sequencer: scoreboard bench comparing every output cycle against a timeline reference model
module tb_clefia_dp_sequencer;
  typedef struct packed {
    logic       busy;
    logic       done;
    logic [5:0] rk_addr;
    logic [1:0] bank;
    logic [9:0] sel;
  } obs_t;
  typedef struct {
    int   cyc;
    obs_t o;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int free_cyc = 0;
  int rst_cycle = -10;
  bit mon_en = 1'b0;
  logic [9:0] model_sel = '0;
  obs_t held = '0;
  rec_t q[$];
  clefia_dp_sequencer_if bus();
  clefia_dp_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // selects as listed per phase: {mux1, mux2, mux3, mux4, mux5, f}
  function automatic logic [9:0] ref_sel(int m, int p);
    int r;
    if (p == 0) return '0;
    if (m != 2) begin
      if (p == 1) return {2'd3, 1'b0, 2'd0, 3'd1, 1'b0, 1'b1};
      return {2'd3, 1'b1, (p % 2 == 1) ? 2'd1 : 2'd2, 3'd1, 1'b1, (p % 2 == 1) ? 1'b1 : 1'b0};
    end
    if (p == 1) return {2'd3, 1'b0, 2'd0, 3'd1, 1'b0, 1'b1};
    if (p == 2) return {2'd1, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0};
    if (p == 3) return {2'd2, 1'b0, 2'd0, 3'd3, 1'b0, 1'b1};
    r = (p - 4) % 4;
    return {2'd2, 1'b1, (r == 3) ? 2'd0 : 2'd1, 3'd4, 1'b0, (r % 2 == 1) ? 1'b1 : 1'b0};
  endfunction
  function automatic int n_of(int m);
    return m == 1 ? 24 : m == 2 ? 40 : 36;
  endfunction
  // drive one cycle of stimulus; an accepted start pushes the whole expected run onto the scoreboard
  task automatic step(input logic r, input logic s, input logic [1:0] m);
    int c, n;
    rec_t e;
    c = cyc;
    rst = r;
    bus.start = s;
    bus.mode = m;
    if (r) begin
      while (q.size() > 0 && q[$].cyc > c) void'(q.pop_back());
      free_cyc = c + 1;
      model_sel = '0;
      rst_cycle = c;
    end else if (s && m != 2'd3 && c >= free_cyc) begin
      n = n_of(int'(m));
      for (int p = -1; p <= n + 1; p++) begin
        e.cyc = c + 2 + p;
        e.o.busy = 1'b1;
        e.o.done = p == n + 1;
        e.o.bank = m;
        e.o.rk_addr = p < 0 ? 6'd0 : 6'((p + 1 < n) ? p + 1 : n - 1);
        e.o.sel = p < 0 ? model_sel : ref_sel(int'(m), p < n ? p : n - 1);
        q.push_back(e);
      end
      model_sel = ref_sel(int'(m), n - 1);
      free_cyc = c + n + 4;
    end
    @(posedge clk);
    #1;
  endtask
  // monitor: busy cycles must match the next queued record, idle cycles must hold the last presented values
  always @(negedge clk) begin
    obs_t obs;
    rec_t r;
    if (mon_en) begin
      obs = {bus.busy, bus.done, bus.rk_addr, bus.rk_bank, bus.sel_mux_1, bus.sel_mux_2, bus.sel_mux_3,
             bus.sel_mux_4, bus.sel_mux_5, bus.selecao_f0_f1};
      if (cyc == rst_cycle + 1) held = '0;
      checks++;
      if (bus.busy) begin
        if (q.size() == 0) begin
          failures++;
          $display("FAIL busy_unexpected cyc=%0d got=%h expected idle", cyc, obs);
        end else begin
          r = q.pop_front();
          if (r.cyc != cyc || obs !== r.o) begin
            failures++;
            $display("FAIL run_output cyc=%0d got=%h expected=%h at cyc %0d", cyc, obs, r.o, r.cyc);
          end
          held = r.o;
          held.busy = 1'b0;
          held.done = 1'b0;
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        failures++;
        $display("FAIL run_missing cyc=%0d got=%h expected=%h", cyc, obs, q[0].o);
      end else if (obs !== held) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d got=%h expected=%h", cyc, obs, held);
      end
    end
  end
  initial begin
    bus.start = 1'b0;
    bus.mode = 2'd0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0);
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0);
    for (int m = 0; m < 3; m++) begin
      step(1'b0, 1'b1, 2'(m));
      for (int i = 0; i < n_of(m) + 6; i++) step(1'b0, 1'b0, 2'd0);
    end
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 2'($urandom_range(0, 2)));
    for (int i = 0; i < 45; i++) step(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 42; i++) step(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 60 && q.size() > 0; i++) step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
